// File: rtl/cdda_stream_pkg.sv
// Shared CD-DA constants: stereo word layout and the per-channel volume rule.
package cdda_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  localparam int L_LSB = 0;
  localparam int L_MSB = 15;
  localparam int R_LSB = 16;
  localparam int R_MSB = 31;

  // vol 15 passes the sample through, each step down halves it, 0 mutes
  function automatic logic signed [SAMPLE_W-1:0] vol_shift(
    input logic signed [SAMPLE_W-1:0] sample,
    input logic        [3:0]          vol
  );
    if (vol == 4'd0)
      vol_shift = '0;
    else
      vol_shift = sample >>> (4'd15 - vol);
  endfunction

endpackage

// File: rtl/cdda_rate_tick.sv
// Fractional-rate strobe: TICK is high for one CLK cycle at SAMPLE_RATE on average, jitter <= 1 CLK.
// TICK is combinational from the accumulator so it can qualify logic in the same cycle.
module cdda_rate_tick #(
  parameter int unsigned CLK_RATE    = 30000000,
  parameter int unsigned SAMPLE_RATE = 44100
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  logic [31:0] acc;
  logic [31:0] nxt;

  // CLK_RATE < 2^31 keeps acc + SAMPLE_RATE inside 32 bits
  assign nxt  = acc + SAMPLE_RATE;
  assign TICK = (nxt >= CLK_RATE);

  always_ff @(posedge CLK) begin
    if (RESET)
      acc <= '0;
    else if (TICK)
      acc <= nxt - CLK_RATE;
    else
      acc <= nxt;
  end

endmodule

// File: rtl/cdda_stream.sv
// CD-DA sample buffer: RAM FIFO filled by the sector engine, replayed at SAMPLE_RATE; sample out 2 cycles after tick.
// Define CDDA_STREAM_STATS_EN to add saturating UNDERRUN_CNT / OVERFLOW_CNT outputs.
module cdda_stream
  import cdda_pkg::*;
#(
  parameter int unsigned CLK_RATE     = 30000000,
  parameter int unsigned SAMPLE_RATE  = 44100,
  parameter int unsigned SECTOR_WORDS = 588,
  parameter int unsigned DEPTH_LOG2   = 11
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  PAUSE,
  input  logic                  WR,
  input  logic [31:0]           DATA,
  output logic                  REQ,
  input  logic [3:0]            VOLUME_L,
  input  logic [3:0]            VOLUME_R,
  input  logic                  MONO,
  input  logic                  SWAP,
  output logic                  AUDIO_CE,
  output logic [15:0]           AUDIO_L,
  output logic [15:0]           AUDIO_R,
  output logic [DEPTH_LOG2:0]   FILL,
  output logic                  OVERFLOW,
  output logic                  UNDERRUN
`ifdef CDDA_STREAM_STATS_EN
 ,output logic [15:0]           UNDERRUN_CNT,
  output logic [15:0]           OVERFLOW_CNT
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int          AW    = DEPTH_LOG2;
  localparam int          FW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FILL_FULL = FW'(DEPTH);
  localparam logic [DEPTH_LOG2:0] REQ_MAX   = FW'(DEPTH - SECTOR_WORDS);

  logic                       tick;
  logic [WORD_W-1:0]          mem [DEPTH];
  logic [AW-1:0]              wptr;
  logic [AW-1:0]              rptr;
  logic [WORD_W-1:0]          rd_dat;
  logic                       s1_vld;
  logic                       s1_silent;
  logic                       pop;
  logic                       wr_ok;
  logic [DEPTH_LOG2:0]        fill_nxt;
  logic signed [SAMPLE_W-1:0] l_raw, r_raw, l_sw, r_sw, l_mx, r_mx;
  logic signed [SAMPLE_W:0]   sum;

  cdda_rate_tick #(
    .CLK_RATE    (CLK_RATE),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (tick)
  );

  // A pop frees the slot being written, so a full FIFO still accepts a write on a pop cycle
  assign pop   = tick && !PAUSE && !FLUSH && (FILL != '0);
  assign wr_ok = WR && !FLUSH && ((FILL != FILL_FULL) || pop);

  always_comb begin
    fill_nxt = FILL;
    if (FLUSH)
      fill_nxt = '0;
    else if (wr_ok && !pop)
      fill_nxt = FILL + FW'(1);
    else if (pop && !wr_ok)
      fill_nxt = FILL - FW'(1);
  end

  always_ff @(posedge CLK) begin
    if (wr_ok)
      mem[wptr] <= DATA;
    if (pop)
      rd_dat <= mem[rptr];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr      <= '0;
      rptr      <= '0;
      FILL      <= '0;
      REQ       <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERRUN  <= 1'b0;
      s1_vld    <= 1'b0;
      s1_silent <= 1'b0;
    end else begin
      if (FLUSH) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + AW'(1);
        if (pop)   rptr <= rptr + AW'(1);
      end
      FILL      <= fill_nxt;
      REQ       <= !FLUSH && (fill_nxt <= REQ_MAX);
      OVERFLOW  <= WR && !FLUSH && !wr_ok;
      UNDERRUN  <= tick && !PAUSE && (FILL == '0);
      s1_vld    <= tick;
      s1_silent <= !pop;
    end
  end

  assign l_raw = rd_dat[L_MSB:L_LSB];
  assign r_raw = rd_dat[R_MSB:R_LSB];
  assign l_sw  = SWAP ? r_raw : l_raw;
  assign r_sw  = SWAP ? l_raw : r_raw;
  assign sum   = {l_sw[SAMPLE_W-1], l_sw} + {r_sw[SAMPLE_W-1], r_sw};
  assign l_mx  = MONO ? SAMPLE_W'(sum >>> 1) : l_sw;
  assign r_mx  = MONO ? SAMPLE_W'(sum >>> 1) : r_sw;

  // Every tick yields a strobe; flushed or empty slots just carry silence
  always_ff @(posedge CLK) begin
    if (RESET) begin
      AUDIO_CE <= 1'b0;
      AUDIO_L  <= '0;
      AUDIO_R  <= '0;
    end else begin
      AUDIO_CE <= s1_vld;
      if (s1_vld) begin
        if (s1_silent || FLUSH) begin
          AUDIO_L <= '0;
          AUDIO_R <= '0;
        end else begin
          AUDIO_L <= vol_shift(l_mx, VOLUME_L);
          AUDIO_R <= vol_shift(r_mx, VOLUME_R);
        end
      end
    end
  end

`ifdef CDDA_STREAM_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      UNDERRUN_CNT <= '0;
      OVERFLOW_CNT <= '0;
    end else begin
      if (UNDERRUN && (UNDERRUN_CNT != 16'hFFFF))
        UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
      if (OVERFLOW && (OVERFLOW_CNT != 16'hFFFF))
        OVERFLOW_CNT <= OVERFLOW_CNT + 16'd1;
    end
  end
`endif

endmodule
